// File: rtl/spike_rate_decoder_if.sv
// Result handshake bundle for spike_rate_decoder: rate_out/rate_valid/rate_ready.
// With SPIKE_RATE_DECODER_ISI_EN defined, isi_out travels alongside rate_out.
interface spike_rate_decoder_if #(
    parameter int ACC_W = 8
);
    logic [ACC_W-1:0] rate_out;
    logic             rate_valid;
    logic             rate_ready;
`ifdef SPIKE_RATE_DECODER_ISI_EN
    logic [7:0]       isi_out;

    modport master (output rate_out, output rate_valid, output isi_out, input rate_ready);
    modport slave  (input rate_out, input rate_valid, input isi_out, output rate_ready);
`else
    modport master (output rate_out, output rate_valid, input rate_ready);
    modport slave  (input rate_out, input rate_valid, output rate_ready);
`endif
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts spikes over a programmable window and offers the count on a valid/ready port.
// Optional SPIKE_RATE_DECODER_ISI_EN adds the inter-spike interval of the last two spikes.
module spike_rate_decoder #(
    parameter int ACC_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  spike_in,
    input  logic [7:0]            window_len,
    spike_rate_decoder_if.master  rate_bus,
    output logic                  overrun,
    output logic                  busy
);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t           state, state_next;
    logic [7:0]       remain;
    logic [ACC_W-1:0] acc, acc_sum;
    logic             start_window, result_event;

    assign busy = (state == COUNT);

    always_comb begin
        acc_sum = acc;
        if (spike_in && (acc != {ACC_W{1'b1}}))
            acc_sum = acc + ACC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // The last window cycle always yields a result, even if enable has dropped.
    always_comb begin
        state_next   = state;
        start_window = 1'b0;
        result_event = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (window_len != 8'd0)) begin
                    start_window = 1'b1;
                    state_next   = COUNT;
                end
            end
            COUNT: begin
                if (remain == 8'd1) begin
                    result_event = 1'b1;
                    if (enable && (window_len != 8'd0)) start_window = 1'b1;
                    else                                state_next   = IDLE;
                end else if (!enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain <= 8'd0;
            acc    <= '0;
        end else if (start_window) begin
            remain <= window_len;
            acc    <= '0;
        end else if (state_next == COUNT) begin
            remain <= remain - 8'd1;
            acc    <= acc_sum;
        end else begin
            remain <= 8'd0;
            acc    <= '0;
        end
    end

`ifdef SPIKE_RATE_DECODER_ISI_EN
    logic [7:0] gap, isi_acc, isi_sum;
    logic       seen;

    // gap counts quiet cycles since the previous spike; the interval is gap+1.
    always_comb begin
        isi_sum = isi_acc;
        if (spike_in && seen)
            isi_sum = (gap == 8'hFF) ? 8'hFF : gap + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap     <= 8'd0;
            isi_acc <= 8'd0;
            seen    <= 1'b0;
        end else if (start_window || (state_next != COUNT)) begin
            gap     <= 8'd0;
            isi_acc <= 8'd0;
            seen    <= 1'b0;
        end else begin
            isi_acc <= isi_sum;
            if (spike_in) begin
                seen <= 1'b1;
                gap  <= 8'd0;
            end else if (seen && (gap != 8'hFF)) begin
                gap <= gap + 8'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_bus.rate_out   <= '0;
            rate_bus.rate_valid <= 1'b0;
            overrun             <= 1'b0;
`ifdef SPIKE_RATE_DECODER_ISI_EN
            rate_bus.isi_out    <= 8'd0;
`endif
        end else if (result_event) begin
            if (!rate_bus.rate_valid || rate_bus.rate_ready) begin
                rate_bus.rate_out   <= acc_sum;
                rate_bus.rate_valid <= 1'b1;
`ifdef SPIKE_RATE_DECODER_ISI_EN
                rate_bus.isi_out    <= isi_sum;
`endif
            end else begin
                overrun <= 1'b1;
            end
        end else if (rate_bus.rate_valid && rate_bus.rate_ready) begin
            rate_bus.rate_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed self-checking bench for spike_rate_decoder: a vector table for a single
// window plus hand-written sequences for back-to-back, saturation, overrun and reset.
module tb_spike_rate_decoder;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       spike_in;
    logic [7:0] window_len;
    logic       overrun;
    logic       busy;

    int checks;
    int errors;

    spike_rate_decoder_if #(.ACC_W(8)) bus ();

    spike_rate_decoder #(.ACC_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .spike_in   (spike_in),
        .window_len (window_len),
        .rate_bus   (bus),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       spk;
        logic [7:0] wl;
        logic       rdy;
        logic       exp_busy;
        logic       exp_valid;
        logic [7:0] exp_rate;
        logic       exp_ovr;
        logic [7:0] exp_isi;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic en, input logic spk, input logic [7:0] wl,
                                input logic rdy, input logic eb, input logic ev,
                                input logic [7:0] er, input logic eo, input logic [7:0] ei);
        vec_t v;
        v.en = en; v.spk = spk; v.wl = wl; v.rdy = rdy;
        v.exp_busy = eb; v.exp_valid = ev; v.exp_rate = er; v.exp_ovr = eo; v.exp_isi = ei;
        return v;
    endfunction

    // Inputs change 1 time unit after a rising edge; outputs are read 1 unit after the next one.
    task automatic applyStimulus(input logic en, input logic spk, input logic [7:0] wl, input logic rdy);
        enable         = en;
        spike_in       = spk;
        window_len     = wl;
        bus.rate_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkIsi(input string name, input logic [7:0] expected);
`ifdef SPIKE_RATE_DECODER_ISI_EN
        checkOutput(name, {24'd0, bus.isi_out}, {24'd0, expected});
`else
        if (expected == 8'hFF) $display("[TB] note %s", name);
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        enable         = 1'b0;
        spike_in       = 1'b0;
        window_len     = 8'd0;
        bus.rate_ready = 1'b0;

        // Ten-cycle window, spikes on cycles 2,5,9, length changed mid-window.
        vecs[0]  = mk(1, 0, 10, 1,  1, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0,  5, 1,  1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1,  5, 1,  1, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0,  5, 1,  1, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0,  5, 1,  1, 0, 0, 0, 0);
        vecs[5]  = mk(1, 1,  5, 1,  1, 0, 0, 0, 0);
        vecs[6]  = mk(1, 0,  5, 1,  1, 0, 0, 0, 0);
        vecs[7]  = mk(1, 0,  5, 1,  1, 0, 0, 0, 0);
        vecs[8]  = mk(1, 0,  5, 1,  1, 0, 0, 0, 0);
        vecs[9]  = mk(1, 1,  5, 1,  1, 0, 0, 0, 0);
        vecs[10] = mk(0, 0,  5, 1,  0, 1, 3, 0, 4);
        vecs[11] = mk(0, 0,  5, 1,  0, 0, 3, 0, 4);
        vecs[12] = mk(0, 0,  5, 1,  0, 0, 3, 0, 4);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy",    {31'd0, busy},           32'd0);
        checkOutput("reset_valid",   {31'd0, bus.rate_valid}, 32'd0);
        checkOutput("reset_rate",    {24'd0, bus.rate_out},   32'd0);
        checkOutput("reset_overrun", {31'd0, overrun},        32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].en, vecs[i].spk, vecs[i].wl, vecs[i].rdy);
            checkOutput($sformatf("vec%0d_busy", i),    {31'd0, busy},           {31'd0, vecs[i].exp_busy});
            checkOutput($sformatf("vec%0d_valid", i),   {31'd0, bus.rate_valid}, {31'd0, vecs[i].exp_valid});
            checkOutput($sformatf("vec%0d_rate", i),    {24'd0, bus.rate_out},   {24'd0, vecs[i].exp_rate});
            checkOutput($sformatf("vec%0d_overrun", i), {31'd0, overrun},        {31'd0, vecs[i].exp_ovr});
            checkIsi($sformatf("vec%0d_isi", i), vecs[i].exp_isi);
        end

        $display("[TB] back-to-back windows of 4");
        applyStimulus(1, 1, 4, 1);
        checkOutput("b2b_start_busy", {31'd0, busy}, 32'd1);
        for (int c = 1; c <= 12; c++) begin
            applyStimulus(1, 1, 4, 1);
            checkOutput($sformatf("b2b_c%0d_busy", c),  {31'd0, busy},           32'd1);
            checkOutput($sformatf("b2b_c%0d_valid", c), {31'd0, bus.rate_valid}, (c % 4 == 0) ? 32'd1 : 32'd0);
            if (c % 4 == 0) begin
                checkOutput($sformatf("b2b_c%0d_rate", c), {24'd0, bus.rate_out}, 32'd4);
                checkIsi($sformatf("b2b_c%0d_isi", c), 8'd1);
            end
        end
        applyStimulus(0, 0, 4, 1);
        checkOutput("b2b_abort_busy",  {31'd0, busy},           32'd0);
        checkOutput("b2b_abort_valid", {31'd0, bus.rate_valid}, 32'd0);

        $display("[TB] full 255-cycle window");
        applyStimulus(1, 1, 255, 1);
        for (int c = 1; c <= 255; c++) begin
            applyStimulus((c < 255) ? 1'b1 : 1'b0, 1, 255, 1);
            if (c == 254) begin
                checkOutput("sat_c254_busy",  {31'd0, busy},           32'd1);
                checkOutput("sat_c254_valid", {31'd0, bus.rate_valid}, 32'd0);
            end
        end
        checkOutput("sat_busy",  {31'd0, busy},           32'd0);
        checkOutput("sat_valid", {31'd0, bus.rate_valid}, 32'd1);
        checkOutput("sat_rate",  {24'd0, bus.rate_out},   32'd255);
        checkIsi("sat_isi", 8'd1);
        applyStimulus(0, 0, 255, 1);
        checkOutput("sat_taken_valid", {31'd0, bus.rate_valid}, 32'd0);

        $display("[TB] zero window length");
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1, c[0], 0, 1);
            checkOutput($sformatf("zero_c%0d_busy", c),  {31'd0, busy},           32'd0);
            checkOutput($sformatf("zero_c%0d_valid", c), {31'd0, bus.rate_valid}, 32'd0);
        end
        applyStimulus(0, 0, 0, 1);

        $display("[TB] overrun with stalled consumer");
        applyStimulus(1, 0, 3, 0);
        applyStimulus(1, 1, 3, 0);
        applyStimulus(1, 0, 3, 0);
        applyStimulus(1, 0, 3, 0);
        checkOutput("ovr_w1_busy",  {31'd0, busy},           32'd1);
        checkOutput("ovr_w1_valid", {31'd0, bus.rate_valid}, 32'd1);
        checkOutput("ovr_w1_rate",  {24'd0, bus.rate_out},   32'd1);
        checkOutput("ovr_w1_ovr",   {31'd0, overrun},        32'd0);
        checkIsi("ovr_w1_isi", 8'd0);
        applyStimulus(1, 1, 3, 0);
        checkOutput("ovr_c4_rate", {24'd0, bus.rate_out}, 32'd1);
        applyStimulus(1, 1, 3, 0);
        checkOutput("ovr_c5_rate", {24'd0, bus.rate_out}, 32'd1);
        applyStimulus(0, 1, 3, 0);
        checkOutput("ovr_w2_busy",  {31'd0, busy},           32'd0);
        checkOutput("ovr_w2_valid", {31'd0, bus.rate_valid}, 32'd1);
        checkOutput("ovr_w2_rate",  {24'd0, bus.rate_out},   32'd1);
        checkOutput("ovr_w2_ovr",   {31'd0, overrun},        32'd1);
        checkIsi("ovr_w2_isi", 8'd0);
        applyStimulus(0, 0, 3, 1);
        checkOutput("ovr_taken_valid", {31'd0, bus.rate_valid}, 32'd0);
        checkOutput("ovr_taken_rate",  {24'd0, bus.rate_out},   32'd1);
        checkOutput("ovr_sticky",      {31'd0, overrun},        32'd1);

        $display("[TB] abort then reset mid-window");
        applyStimulus(1, 0, 10, 1);
        for (int c = 1; c <= 4; c++) applyStimulus(1, c[0], 10, 1);
        applyStimulus(0, 1, 10, 1);
        checkOutput("abort_busy",  {31'd0, busy},           32'd0);
        checkOutput("abort_valid", {31'd0, bus.rate_valid}, 32'd0);
        checkOutput("abort_rate",  {24'd0, bus.rate_out},   32'd1);
        checkOutput("abort_ovr",   {31'd0, overrun},        32'd1);
        applyStimulus(1, 1, 10, 1);
        for (int c = 1; c <= 3; c++) applyStimulus(1, 1, 10, 1);
        checkOutput("prereset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy",  {31'd0, busy},           32'd0);
        checkOutput("rst_valid", {31'd0, bus.rate_valid}, 32'd0);
        checkOutput("rst_rate",  {24'd0, bus.rate_out},   32'd0);
        checkOutput("rst_ovr",   {31'd0, overrun},        32'd0);
        checkIsi("rst_isi", 8'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_held_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_release_busy", {31'd0, busy}, 32'd0);
        applyStimulus(1, 0, 10, 1);
        checkOutput("resume_busy", {31'd0, busy}, 32'd1);
        applyStimulus(0, 0, 10, 1);
        checkOutput("resume_abort_busy",  {31'd0, busy},           32'd0);
        checkOutput("resume_abort_valid", {31'd0, bus.rate_valid}, 32'd0);
        checkOutput("resume_abort_ovr",   {31'd0, overrun},        32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
